// File: rtl/all_gates_u2.sv
// Registered bitwise gate bank (NOT/AND/OR/NAND/NOR/XOR/XNOR) with a sticky
// result-valid flag and a saturating counter of input changes.
module all_gates_u2 #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out_not,
    output logic [WIDTH-1:0] out_and,
    output logic [WIDTH-1:0] out_or,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] out_nand,
    output logic [WIDTH-1:0] out_nor,
    output logic [WIDTH-1:0] out_xor,
    output logic [WIDTH-1:0] out_xnor,
    output logic             out_valid,
    output logic [CNT_W-1:0] chg_cnt
);

    // out_valid is a plain status qualifier, not a handshake: it rises on the
    // first non-reset edge and stays high until the next reset. No ready.

    logic [2*WIDTH-1:0] prev_ab;
    logic               prev_valid;
    logic [2*WIDTH-1:0] cur_ab;
    logic               changed;
    logic               cnt_full;

    assign cur_ab   = {a, b};
    assign changed  = prev_valid && (cur_ab != prev_ab);
    assign cnt_full = (chg_cnt == {CNT_W{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) begin
            out_not    <= '0;
            out_and    <= '0;
            out_or     <= '0;
            out_nand   <= '0;
            out_nor    <= '0;
            out_xor    <= '0;
            out_xnor   <= '0;
            out_valid  <= 1'b0;
            chg_cnt    <= '0;
            prev_ab    <= '0;
            prev_valid <= 1'b0;
        end else begin
            out_not    <= ~a;
            out_and    <= a & b;
            out_or     <= a | b;
            out_nand   <= ~(a & b);
            out_nor    <= ~(a | b);
            out_xor    <= a ^ b;
            out_xnor   <= ~(a ^ b);
            out_valid  <= 1'b1;
            prev_ab    <= cur_ab;
            prev_valid <= 1'b1;
            // Saturate rather than wrap so a long-running count never reads low.
            if (changed && !cnt_full) begin
                chg_cnt <= chg_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_all_gates_u2.sv
// Scoreboarded bench for all_gates_u2: a default 1-bit instance and a 4-bit
// instance with a 2-bit change counter, driven in lockstep from one clock.
module tb_all_gates_u2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance 0: WIDTH=1, CNT_W=8
    logic [0:0] a0, b0;
    logic [0:0] not0, and0, or0, nand0, nor0, xor0, xnor0;
    logic       valid0;
    logic [7:0] cnt0;

    // Instance 1: WIDTH=4, CNT_W=2
    logic [3:0] a1, b1;
    logic [3:0] not1, and1, or1, nand1, nor1, xor1, xnor1;
    logic       valid1;
    logic [1:0] cnt1;

    all_gates_u2 #(.WIDTH(1), .CNT_W(8)) dut0 (
        .a(a0), .b(b0), .out_not(not0), .out_and(and0), .out_or(or0),
        .clk(clk), .rst(rst), .out_nand(nand0), .out_nor(nor0),
        .out_xor(xor0), .out_xnor(xnor0), .out_valid(valid0), .chg_cnt(cnt0)
    );

    all_gates_u2 #(.WIDTH(4), .CNT_W(2)) dut1 (
        .a(a1), .b(b1), .out_not(not1), .out_and(and1), .out_or(or1),
        .clk(clk), .rst(rst), .out_nand(nand1), .out_nor(nor1),
        .out_xor(xor1), .out_xnor(xnor1), .out_valid(valid1), .chg_cnt(cnt1)
    );

    // Scoreboard: expected output words pushed when inputs are driven
    logic [15:0] exp0_q[$];
    logic [30:0] exp1_q[$];

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    logic [1:0] m0_prev;
    logic       m0_pv;
    logic [7:0] m0_cnt;
    logic [7:0] m1_prev;
    logic       m1_pv;
    logic [1:0] m1_cnt;

    initial begin
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        m0_prev = '0; m0_pv = 1'b0; m0_cnt = '0;
        m1_prev = '0; m1_pv = 1'b0; m1_cnt = '0;
    end

    // One clock: drive at negedge, predict, then compare #1 after posedge
    task automatic step(input logic r, input logic a0v, input logic b0v,
                        input logic [3:0] a1v, input logic [3:0] b1v);
        logic [15:0] e0, g0;
        logic [30:0] e1, g1;
        @(negedge clk);
        rst = r; a0 = a0v; b0 = b0v; a1 = a1v; b1 = b1v;
        if (r) begin
            m0_prev = '0; m0_pv = 1'b0; m0_cnt = '0;
            m1_prev = '0; m1_pv = 1'b0; m1_cnt = '0;
            e0 = '0;
            e1 = '0;
        end else begin
            if (m0_pv && ({a0v, b0v} != m0_prev) && (m0_cnt != 8'hFF)) m0_cnt = m0_cnt + 8'd1;
            m0_prev = {a0v, b0v}; m0_pv = 1'b1;
            if (m1_pv && ({a1v, b1v} != m1_prev) && (m1_cnt != 2'd3)) m1_cnt = m1_cnt + 2'd1;
            m1_prev = {a1v, b1v}; m1_pv = 1'b1;
            e0 = {~a0v, a0v & b0v, a0v | b0v, ~(a0v & b0v), ~(a0v | b0v),
                  a0v ^ b0v, ~(a0v ^ b0v), 1'b1, m0_cnt};
            e1 = {~a1v, a1v & b1v, a1v | b1v, ~(a1v & b1v), ~(a1v | b1v),
                  a1v ^ b1v, ~(a1v ^ b1v), 1'b1, m1_cnt};
        end
        exp0_q.push_back(e0);
        exp1_q.push_back(e1);
        @(posedge clk);
        #1;
        g0 = {not0, and0, or0, nand0, nor0, xor0, xnor0, valid0, cnt0};
        g1 = {not1, and1, or1, nand1, nor1, xor1, xnor1, valid1, cnt1};
        e0 = exp0_q.pop_front();
        e1 = exp1_q.pop_front();
        n_vec++;
        if (g0 !== e0) begin
            n_bad++;
            $display("FAIL sb_w1 got %h want %h (not,and,or,nand,nor,xor,xnor,valid,cnt)", g0, e0);
        end
        n_vec++;
        if (g1 !== e1) begin
            n_bad++;
            $display("FAIL sb_w4 got %h want %h (not,and,or,nand,nor,xor,xnor,valid,cnt)", g1, e1);
        end
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 1'b1, 4'hF, 4'hF);
        step(1'b1, 1'b1, 1'b1, 4'hF, 4'hF);
        n_vec++;
        if ({not0, and0, or0, nand0, nor0, xor0, xnor0, valid0, cnt0} !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_w1 got %h want 0000",
                     {not0, and0, or0, nand0, nor0, xor0, xnor0, valid0, cnt0});
        end
        // First edge after release behaves as the first sample
        step(1'b0, 1'b1, 1'b1, 4'hF, 4'hF);
        n_vec++;
        if (and0 !== 1'b1 || valid0 !== 1'b1 || cnt0 !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_release got and=%b valid=%b cnt=%0d want and=1 valid=1 cnt=0",
                     and0, valid0, cnt0);
        end
    endtask

    task automatic test_truth_table();
        logic [3:0] t_not  = 4'b1100;
        logic [3:0] t_and  = 4'b0001;
        logic [3:0] t_or   = 4'b0111;
        logic [3:0] t_nand = 4'b1110;
        logic [3:0] t_nor  = 4'b1000;
        logic [3:0] t_xor  = 4'b0110;
        logic [3:0] t_xnor = 4'b1001;
        logic [3:0] ab;
        step(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            ab = i[3:0];
            step(1'b0, ab[1], ab[0], 4'h0, 4'h0);
            n_vec++;
            if ({not0, and0, or0, nand0, nor0, xor0, xnor0, valid0} !==
                {t_not[3-i], t_and[3-i], t_or[3-i], t_nand[3-i], t_nor[3-i],
                 t_xor[3-i], t_xnor[3-i], 1'b1} || cnt0 !== 8'(i)) begin
                n_bad++;
                $display("FAIL truth_ab%0d got %b%b%b%b%b%b%b v%b c%0d want %b%b%b%b%b%b%b v1 c%0d",
                         i, not0, and0, or0, nand0, nor0, xor0, xnor0, valid0, cnt0,
                         t_not[3-i], t_and[3-i], t_or[3-i], t_nand[3-i], t_nor[3-i],
                         t_xor[3-i], t_xnor[3-i], i);
            end
        end
    endtask

    task automatic test_hold();
        logic [7:0] held;
        step(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
        held = m0_cnt;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
            n_vec++;
            if (cnt0 !== held || or0 !== 1'b1 || xor0 !== 1'b1 || and0 !== 1'b0) begin
                n_bad++;
                $display("FAIL hold_%0d got cnt=%0d or=%b xor=%b and=%b want cnt=%0d or=1 xor=1 and=0",
                         i, cnt0, or0, xor0, and0, held);
            end
        end
    endtask

    task automatic test_saturate();
        step(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'(i % 2), 1'b0, (i % 2 == 1) ? 4'hF : 4'h0, 4'h0);
        end
        n_vec++;
        if (cnt1 !== 2'd3) begin
            n_bad++;
            $display("FAIL saturate got cnt=%0d want 3", cnt1);
        end
    endtask

    task automatic test_width4();
        step(1'b0, 1'b0, 1'b0, 4'b1100, 4'b1010);
        n_vec++;
        if (and1 !== 4'b1000 || or1 !== 4'b1110 || xor1 !== 4'b0110 || not1 !== 4'b0011) begin
            n_bad++;
            $display("FAIL width4 got and=%b or=%b xor=%b not=%b want 1000 1110 0110 0011",
                     and1, or1, xor1, not1);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            step(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)));
        end
    endtask

    initial begin
        test_reset();
        test_truth_table();
        test_hold();
        test_saturate();
        test_width4();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/all_gates_u2.md
ALL_GATES_U2 -- requirements
Module: all_gates_u2

Interface
REQ-001 Parameter: WIDTH, default 1, operand width in bits; all gate operations are bitwise.
REQ-002 Parameter: CNT_W, default 8, width of the input-change counter.
REQ-003 The block SHALL use one clock, clk; reset, rst, SHALL be synchronous and active-high.
REQ-004 Port: clk  input  1  rising-edge clock for all state.
REQ-005 Port: rst  input  1  synchronous active-high reset.
REQ-006 Port: a  input  WIDTH  operand A.
REQ-007 Port: b  input  WIDTH  operand B.
REQ-008 Port: out_not  output  WIDTH  registered ~a.
REQ-009 Port: out_and  output  WIDTH  registered a & b.
REQ-010 Port: out_or  output  WIDTH  registered a | b.
REQ-011 Port: out_nand  output  WIDTH  registered ~(a & b).
REQ-012 Port: out_nor  output  WIDTH  registered ~(a | b).
REQ-013 Port: out_xor  output  WIDTH  registered a ^ b.
REQ-014 Port: out_xnor  output  WIDTH  registered ~(a ^ b).
REQ-015 Port: out_valid  output  1  high when the gate outputs hold a result computed from sampled inputs.
REQ-016 Port: chg_cnt  output  CNT_W  count of cycles in which the sampled {a,b} differed from the previous sample.
REQ-017 Port declaration order SHALL be a, b, out_not, out_and, out_or, then clk, rst, out_nand, out_nor, out_xor, out_xnor, out_valid, chg_cnt, so that the first five ports are usable positionally.

Function
REQ-018 On every rising clk edge with rst low, the block SHALL sample a and b and update all seven gate outputs from the sampled values; latency is exactly 1 cycle.
REQ-019 Gate outputs SHALL change only on a rising clk edge; no combinational path from a/b to any output.
REQ-020 out_valid SHALL go high on the first rising edge with rst low after reset and remain high until the next reset.
REQ-021 The block SHALL hold the previous sampled {a,b} internally; prev_valid is cleared by reset and set on the first sample.
REQ-022 chg_cnt SHALL increment by 1 on an edge where prev_valid is 1 and the new {a,b} differs from the held previous sample in any bit.
REQ-023 The first sample after reset SHALL NOT increment chg_cnt.
REQ-024 chg_cnt SHALL saturate at 2^CNT_W-1; it does not wrap.
REQ-025 X/Z on inputs need not be handled; outputs follow standard bitwise operator semantics.

Reset
REQ-026 With rst high at a rising edge: out_not, out_and, out_or, out_nand, out_nor, out_xor, out_xnor = 0; out_valid = 0; chg_cnt = 0; prev_valid = 0.
REQ-027 rst SHALL take priority over sampling; reset asserted mid-operation clears all state on that edge, and the next non-reset edge behaves as the first sample.

Verification
REQ-028 WIDTH=1, {a,b}=00,01,10,11, one per cycle -> one cycle later out_not=1,1,0,0; out_and=0,0,0,1; out_or=0,1,1,1.
REQ-029 Same sequence -> out_nand=1,1,1,0; out_nor=1,0,0,0; out_xor=0,1,1,0; out_xnor=1,0,0,1; out_valid=1 from the first result; chg_cnt=0,1,2,3.
REQ-030 rst high for 2 cycles with a=1,b=1 -> all outputs 0, out_valid 0; first edge after release -> out_and=1, out_valid=1, chg_cnt=0.
REQ-031 Hold {a,b}=10 for 10 cycles -> outputs stable, chg_cnt unchanged.
REQ-032 CNT_W=2, toggle a every cycle for 6 cycles -> chg_cnt saturates at 3.
REQ-033 WIDTH=4, a=4'b1100, b=4'b1010 -> out_and=1000, out_or=1110, out_xor=0110, out_not=0011 one cycle later.
